// File: rtl/fa_pkg.sv
// Shared types for the bit-serial full-adder scheduler.
// Holds the state encoding, default latency and sizing helper.
package fa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } fa_state_t;

  localparam int FA_LAT_DEF = 2;

  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fa_lat_model.sv
// Behavioural fa_a cell: sum and majority delayed FA_LAT clocks.
// Only issued triples (vld=1) produce pulses.
module fa_lat_model
  import fa_pkg::*;
#(
  parameter int FA_LAT = FA_LAT_DEF
) (
  input  logic TI,
  input  logic RI,
  input  logic ai,
  input  logic bi,
  input  logic ci,
  input  logic vld,
  output logic so,
  output logic co
);

  logic [FA_LAT-1:0] s_sr;
  logic [FA_LAT-1:0] c_sr;
  logic s_in;
  logic c_in;

  assign s_in = vld & (ai ^ bi ^ ci);
  assign c_in = vld & ((ai & bi) | (ai & ci) | (bi & ci));

  always_ff @(posedge TI or posedge RI) begin
    if (RI) begin
      s_sr <= '0;
      c_sr <= '0;
    end else begin
      s_sr <= FA_LAT'({s_sr, s_in});
      c_sr <= FA_LAT'({c_sr, c_in});
    end
  end

  assign so = s_sr[FA_LAT-1];
  assign co = c_sr[FA_LAT-1];

endmodule

// File: rtl/fa_serial_ctrl.sv
// Bit-serial scheduler driving one shared fa_a cell, LSB first.
// Carry is looped back through the cell between bit passes.
module fa_serial_ctrl
  import fa_pkg::*;
#(
  parameter int W      = 4,
  parameter int FA_LAT = FA_LAT_DEF
) (
  input  logic         TI,
  input  logic         RI,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_out,
  output logic         co_out,
  output logic         fa_ai,
  output logic         fa_bi,
  output logic         fa_ci,
  output logic         fa_vld,
  input  logic         fa_so,
  input  logic         fa_co,
  output logic         busy
);

  localparam int IW = clog2_min1(W);
  localparam int CW = clog2_min1(FA_LAT);

  generate
    if (W < 1 || FA_LAT < 1) begin : g_bad_param
      $error("fa_serial_ctrl: W and FA_LAT must be >= 1");
    end
  endgenerate

  fa_state_t     state;
  fa_state_t     nstate;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic [W-1:0]  sum_nx;
  logic [IW-1:0] idx;
  logic [CW-1:0] wcnt;
  logic          carry;
  logic          last_bit;
  logic          smp;

  assign last_bit = (idx == IW'(W - 1));
  assign smp      = (state == WAIT) && (wcnt == '0);

  always_comb begin
    sum_nx      = sum_q;
    sum_nx[idx] = fa_so;
  end

  always_ff @(posedge TI or posedge RI) begin
    if (RI) state <= IDLE;
    else    state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid)  nstate = ISSUE;
      ISSUE:                  nstate = WAIT;
      WAIT:    if (wcnt == '0)
                 nstate = last_bit ? DONE : ISSUE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    fa_vld    = 1'b0;
    fa_ai     = 1'b0;
    fa_bi     = 1'b0;
    fa_ci     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      (state == ISSUE): begin
        fa_vld = 1'b1;
        fa_ai  = a_q[idx];
        fa_bi  = b_q[idx];
        fa_ci  = carry;
      end
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result registers only load on DONE entry so they survive the next op.
  always_ff @(posedge TI or posedge RI) begin
    if (RI) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      wcnt    <= '0;
      carry   <= 1'b0;
      sum_out <= '0;
      co_out  <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q   <= a_in;
        b_q   <= b_in;
        carry <= c_in;
        idx   <= '0;
      end
      if (state == ISSUE)
        wcnt <= CW'(FA_LAT - 1);
      if (state == WAIT && wcnt != '0)
        wcnt <= wcnt - 1'b1;
      if (smp) begin
        sum_q <= sum_nx;
        carry <= fa_co;
        if (last_bit) begin
          sum_out <= sum_nx;
          co_out  <= fa_co;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Bench for fa_serial_ctrl with fa_lat_model cells attached.
// Two instances: W=4/FA_LAT=2 directed, W=8/FA_LAT=1 random.
module tb_fa_serial_ctrl;

  logic TI = 1'b0;
  always #5 TI = ~TI;

  logic       rst0, iv0, ir0, ov0, or0, c0, co0;
  logic       ai0, bi0, ci0, v0, so0, fco0, busy0;
  logic [3:0] a0, b0, s0;

  logic       rst1, iv1, ir1, ov1, or1, c1, co1;
  logic       ai1, bi1, ci1, v1, so1, fco1, busy1;
  logic [7:0] a1, b1, s1;

  int n_cmp = 0;
  int n_err = 0;
  int pulses0, gapbad0;

  logic [4:0] q0[$];
  logic [8:0] q1[$];

  fa_serial_ctrl #(.W(4), .FA_LAT(2)) u_dut0 (
    .TI(TI), .RI(rst0),
    .in_valid(iv0), .in_ready(ir0),
    .a_in(a0), .b_in(b0), .c_in(c0),
    .out_valid(ov0), .out_ready(or0),
    .sum_out(s0), .co_out(co0),
    .fa_ai(ai0), .fa_bi(bi0), .fa_ci(ci0),
    .fa_vld(v0), .fa_so(so0), .fa_co(fco0),
    .busy(busy0)
  );

  fa_lat_model #(.FA_LAT(2)) u_fa0 (
    .TI(TI), .RI(rst0),
    .ai(ai0), .bi(bi0), .ci(ci0), .vld(v0),
    .so(so0), .co(fco0)
  );

  fa_serial_ctrl #(.W(8), .FA_LAT(1)) u_dut1 (
    .TI(TI), .RI(rst1),
    .in_valid(iv1), .in_ready(ir1),
    .a_in(a1), .b_in(b1), .c_in(c1),
    .out_valid(ov1), .out_ready(or1),
    .sum_out(s1), .co_out(co1),
    .fa_ai(ai1), .fa_bi(bi1), .fa_ci(ci1),
    .fa_vld(v1), .fa_so(so1), .fa_co(fco1),
    .busy(busy1)
  );

  fa_lat_model #(.FA_LAT(1)) u_fa1 (
    .TI(TI), .RI(rst1),
    .ai(ai1), .bi(bi1), .ci(ci1), .vld(v1),
    .so(so1), .co(fco1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready0();
    int k;
    k = 0;
    while (!ir0 && k < 50) begin
      @(negedge TI);
      k++;
    end
    check("rdy0", 32'(ir0), 32'd1);
  endtask

  task automatic run0(input logic [3:0] a,
                      input logic [3:0] b,
                      input logic       c,
                      input int         hold,
                      input bit         noise);
    int lat, np, last, gb;
    logic [4:0] hs;
    logic [4:0] exp;
    lat = 0; np = 0; last = 0; gb = 0;
    wait_ready0();
    a0 = a; b0 = b; c0 = c; iv0 = 1'b1;
    q0.push_back(5'(a) + 5'(b) + 5'(c));
    @(negedge TI);
    lat = 1;
    if (!noise) iv0 = 1'b0;
    while (!ov0 && lat < 60) begin
      if (v0) begin
        if (np > 0 && lat - last != 3) gb++;
        np++;
        last = lat;
      end
      if (noise) begin
        a0 = 4'($urandom);
        b0 = 4'($urandom);
        c0 = 1'($urandom);
      end
      @(negedge TI);
      lat++;
    end
    iv0 = 1'b0;
    pulses0 = np;
    gapbad0 = gb;
    check("lat0", 32'(lat), 32'd13);
    hs = {co0, s0};
    for (int i = 0; i < hold; i++) begin
      check("hold0", 32'({ov0, ir0, busy0, co0, s0}),
            32'({3'b101, hs}));
      @(negedge TI);
    end
    check("xfer_ir0", 32'(ir0), 32'd0);
    or0 = 1'b1;
    exp = q0.pop_front();
    check("sum0", 32'({co0, s0}), 32'(exp));
    @(negedge TI);
    or0 = 1'b0;
    check("idle0", 32'({ov0, ir0, busy0}), 32'b010);
  endtask

  initial begin
    rst0 = 1'b1; iv0 = 1'b0; or0 = 1'b0;
    a0 = '0; b0 = '0; c0 = 1'b0;
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b1;
    a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (2) @(negedge TI);
    check("rst_out0",
          32'({ir0, ov0, busy0, v0, ai0, bi0, ci0, co0, s0}),
          32'({1'b1, 11'b0}));
    check("rst_out1", 32'({ir1, ov1, busy1, v1, co1, s1}),
          32'({1'b1, 12'b0}));
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge TI);

    run0(4'hB, 4'h6, 1'b0, 0, 1'b0);
    run0(4'hF, 4'h0, 1'b1, 0, 1'b0);
    check("pulses", 32'(pulses0), 32'd4);
    check("gap", 32'(gapbad0), 32'd0);
    run0(4'h9, 4'h3, 1'b1, 5, 1'b0);

    wait_ready0();
    a0 = 4'h7; b0 = 4'h5; c0 = 1'b1; iv0 = 1'b1;
    @(negedge TI);
    iv0 = 1'b0;
    repeat (6) @(negedge TI);
    check("bit2_issue", 32'(v0), 32'd1);
    @(negedge TI);
    rst0 = 1'b1;
    #1;
    check("rst_mid",
          32'({v0, ov0, ir0, busy0, co0, s0}),
          32'({4'b0010, 5'b0}));
    @(negedge TI);
    rst0 = 1'b0;
    @(negedge TI);
    run0(4'hD, 4'hC, 1'b0, 0, 1'b0);

    run0(4'h5, 4'hA, 1'b1, 2, 1'b1);

    for (int n = 0; n < 500; n++) begin
      int lat, k;
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      k = 0;
      while (!ir1 && k < 50) begin
        @(negedge TI);
        k++;
      end
      check("rdy1", 32'(ir1), 32'd1);
      a1 = ra; b1 = rb; c1 = rc; iv1 = 1'b1;
      q1.push_back(9'(ra) + 9'(rb) + 9'(rc));
      @(negedge TI);
      iv1 = 1'b0;
      a1 = 8'($urandom);
      lat = 1;
      while (!ov1 && lat < 60) begin
        @(negedge TI);
        lat++;
      end
      check("lat1", 32'(lat), 32'd17);
      check("sum1", 32'({co1, s1}), 32'(q1.pop_front()));
      @(negedge TI);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
